// File: rtl/elevator_request_scheduler.sv
// Elevator car controller: latches floor-request pulses into a pending set
// and sequences car motion and door timing with a collective (SCAN) policy.
module elevator_request_scheduler #(
  parameter int unsigned NUM_FLOORS    = 5,
  parameter int unsigned FLOOR_W       = 3,
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4,
  parameter int unsigned TIMER_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req_pulse,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  busy
);

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [NUM_FLOORS-1:0] eff;
  logic [NUM_FLOORS-1:0] pending_next;
  logic [FLOOR_W-1:0]    floor_next;
  logic [FLOOR_W-1:0]    floor_step;
  logic [TIMER_W-1:0]    timer;
  logic [TIMER_W-1:0]    timer_next;
  logic                  dir_up;
  logic                  dir_up_next;
  logic                  above;
  logic                  below;

  // One-hot mask selecting floor f.
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == f) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Mask of all floors strictly above f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) > f) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Mask of all floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) < f) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Next-state, request bookkeeping and timer control.
  always_comb begin
    eff          = pending | req_pulse;
    above        = |(eff & above_mask(current_floor));
    below        = |(eff & below_mask(current_floor));
    state_next   = state;
    pending_next = eff;
    floor_next   = current_floor;
    floor_step   = current_floor;
    timer_next   = timer;
    dir_up_next  = dir_up;

    case (state)
      IDLE: begin
        if (|(eff & floor_mask(current_floor))) begin
          state_next   = DOOR_OPEN;
          pending_next = eff & ~floor_mask(current_floor);
          timer_next   = '0;
        end else if ((dir_up && above) || (above && !below)) begin
          state_next  = MOVE_UP;
          dir_up_next = 1'b1;
          timer_next  = '0;
        end else if (below) begin
          state_next  = MOVE_DOWN;
          dir_up_next = 1'b0;
          timer_next  = '0;
        end
      end

      MOVE_UP, MOVE_DOWN: begin
        dir_up_next = (state == MOVE_UP);
        timer_next  = timer + TIMER_W'(1);
        if (timer == TRAVEL_LAST) begin
          floor_step = (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                          : current_floor - FLOOR_W'(1);
          floor_next = floor_step;
          timer_next = '0;
          if (|(eff & floor_mask(floor_step))) begin
            state_next   = DOOR_OPEN;
            pending_next = eff & ~floor_mask(floor_step);
          end else if ((state == MOVE_UP) ? |(eff & above_mask(floor_step))
                                          : |(eff & below_mask(floor_step))) begin
            state_next = state;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DOOR_OPEN: begin
        // A call for the floor whose door is already open is simply absorbed.
        pending_next = eff & ~floor_mask(current_floor);
        timer_next   = timer + TIMER_W'(1);
        if (timer == DOOR_LAST) begin
          timer_next = '0;
          if (dir_up ? above : below) begin
            state_next = dir_up ? MOVE_UP : MOVE_DOWN;
          end else if (dir_up ? below : above) begin
            state_next  = dir_up ? MOVE_DOWN : MOVE_UP;
            dir_up_next = !dir_up;
          end else begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase
  end

  // State, position, request set and registered indicator outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      current_floor <= '0;
      pending       <= '0;
      timer         <= '0;
      dir_up        <= 1'b1;
      moving_up     <= 1'b0;
      moving_down   <= 1'b0;
      door_open     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      current_floor <= floor_next;
      pending       <= pending_next;
      timer         <= timer_next;
      dir_up        <= dir_up_next;
      moving_up     <= (state_next == MOVE_UP);
      moving_down   <= (state_next == MOVE_DOWN);
      door_open     <= (state_next == DOOR_OPEN);
      busy          <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Randomized scoreboard bench for elevator_request_scheduler against a
// floor/direction-level reference model of the car.
module tb_elevator_request_scheduler;

  localparam int NF     = 5;
  localparam int FW     = 3;
  localparam int TRAVEL = 8;
  localparam int DOOR   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NF-1:0] req_pulse = '0;
  logic [FW-1:0] current_floor;
  logic          moving_up;
  logic          moving_down;
  logic          door_open;
  logic [NF-1:0] pending;
  logic          busy;

  elevator_request_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .TRAVEL_CYCLES(TRAVEL),
    .DOOR_CYCLES(DOOR), .TIMER_W(16)
  ) dut (
    .clk(clk), .rst(rst), .req_pulse(req_pulse),
    .current_floor(current_floor), .moving_up(moving_up),
    .moving_down(moving_down), .door_open(door_open),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int floor;
    int up;
    int down;
    int door;
    int pend;
    int busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: position, motion mode, signed direction, phase age.
  int          m_floor = 0;
  int          m_mode  = 0; // 0 idle, 1 travelling, 2 door open
  int          m_dir   = 1; // +1 up, -1 down
  int          m_age   = 0;
  bit [NF-1:0] m_pend  = '0;

  function automatic bit want(bit [NF-1:0] v, int f, int d);
    for (int i = 0; i < NF; i++)
      if (v[i] && (i - f) * d > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(bit r, bit [NF-1:0] req);
    bit [NF-1:0] calls;
    if (r) begin
      m_floor = 0; m_mode = 0; m_dir = 1; m_age = 0; m_pend = '0;
      return;
    end
    calls = m_pend | req;
    case (m_mode)
      0: begin
        if (calls[m_floor]) begin
          calls[m_floor] = 1'b0; m_mode = 2; m_age = 0;
        end else if (want(calls, m_floor, 1) && (m_dir == 1 || !want(calls, m_floor, -1))) begin
          m_mode = 1; m_dir = 1; m_age = 0;
        end else if (want(calls, m_floor, -1)) begin
          m_mode = 1; m_dir = -1; m_age = 0;
        end
      end
      1: begin
        m_age++;
        if (m_age == TRAVEL) begin
          m_floor += m_dir;
          m_age = 0;
          if (m_floor < 0 || m_floor >= NF) begin
            errors++;
            $display("FAIL model_range floor=%0d out of 0..%0d", m_floor, NF - 1);
            m_floor = 0;
          end
          if (calls[m_floor]) begin
            calls[m_floor] = 1'b0; m_mode = 2;
          end else if (!want(calls, m_floor, m_dir)) begin
            m_mode = 0;
          end
        end
      end
      default: begin
        calls[m_floor] = 1'b0;
        m_age++;
        if (m_age == DOOR) begin
          m_age = 0;
          if (want(calls, m_floor, m_dir)) m_mode = 1;
          else if (want(calls, m_floor, -m_dir)) begin m_dir = -m_dir; m_mode = 1; end
          else m_mode = 0;
        end
      end
    endcase
    m_pend = calls;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the edge.
  task automatic cycle(bit r, bit [NF-1:0] req);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    req_pulse = req;
    model_step(r, req);
    e.due   = cyc + 1;
    e.floor = m_floor;
    e.up    = (m_mode == 1 && m_dir == 1) ? 1 : 0;
    e.down  = (m_mode == 1 && m_dir == -1) ? 1 : 0;
    e.door  = (m_mode == 2) ? 1 : 0;
    e.pend  = int'(m_pend);
    e.busy  = (m_mode != 0) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) cycle(1'b0, '0);
  endtask

  task automatic chk(string name, int act, int exp, int at);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, at, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("current_floor", int'(current_floor), e.floor, e.due);
        chk("moving_up", int'(moving_up), e.up, e.due);
        chk("moving_down", int'(moving_down), e.down, e.due);
        chk("door_open", int'(door_open), e.door, e.due);
        chk("pending", int'(pending), e.pend, e.due);
        chk("busy", int'(busy), e.busy, e.due);
      end
    end
  end

  initial begin
    bit [NF-1:0] r;
    // Reset state.
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    // Call at the current floor: door opens immediately.
    cycle(1'b0, 5'b00001);
    idle(6);
    // Single trip up to floor 3.
    cycle(1'b0, 5'b01000);
    idle(34);
    // From floor 3 heading up: calls at 1 and 4 together.
    cycle(1'b0, 5'b10010);
    idle(60);
    // Trip 0 -> 4 with an intermediate stop and a call just passed.
    cycle(1'b1, '0);
    cycle(1'b0, 5'b10000);
    idle(10);
    cycle(1'b0, 5'b00100);
    idle(19);
    cycle(1'b0, 5'b00010);
    idle(80);
    // Reset mid-move at floor 2 with calls at 3 and 4 outstanding.
    cycle(1'b1, '0);
    cycle(1'b0, 5'b11000);
    idle(20);
    cycle(1'b1, '0);
    idle(3);
    // Same-floor call while the door is open, including on its last cycle.
    cycle(1'b0, 5'b00100);
    idle(17);
    cycle(1'b0, 5'b00100);
    idle(1);
    cycle(1'b0, 5'b00100);
    idle(10);
    // Randomized traffic with occasional resets.
    for (int k = 0; k < 5000; k++) begin
      r = '0;
      if ($urandom_range(0, 11) == 0) r = NF'($urandom);
      cycle($urandom_range(0, 699) == 0, r);
    end
    idle(4);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
